// File: rtl/wpa2_fetch_pkg.sv
// ---------------------------------------------------------------------------
// wpa2_fetch_pkg
// Shared definitions for the WPA2 message block fetcher.
//   WORDS_PER_BLOCK / WORD_W / BLOCK_W : geometry of one SHA-1 message block
//   state_t                            : fetcher FSM encoding (also exported
//                                        on the top-level dbg_state port)
//   wrap_next_addr()                   : next word address, wrapping at the
//                                        end of the valid memory range
//
// Stream handshake used by the fetcher output:
//   A block moves from producer to consumer on every rising clk edge where
//   valid=1 and ready=1. While valid=1 and ready=0 the producer holds data,
//   valid and last stable. Valid never depends combinationally on ready.
// ---------------------------------------------------------------------------
package wpa2_fetch_pkg;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    // Memory holds 'depth' valid words; the address after depth-1 is 0.
    function automatic logic [31:0] wrap_next_addr(input logic [31:0] addr,
                                                   input logic [31:0] depth);
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/wpa2_word_packer.sv
// ---------------------------------------------------------------------------
// wpa2_word_packer
// 16 x 32-bit shift-in assembly buffer. Each captured word is shifted in at
// the bottom, so after 16 shifts the first word sits in [511:480] and the
// last in [31:0].
//   clk, reset_n : clock, asynchronous active-low reset
//   i_shift      : capture i_word this cycle (ignored once full)
//   i_word       : word to capture
//   i_clear      : buffer consumed; empty it
//   o_full       : all 16 words captured
//   o_block      : assembled block
// ---------------------------------------------------------------------------
module wpa2_word_packer
    import wpa2_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_shift,
    input  logic [WORD_W-1:0]  i_word,
    input  logic               i_clear,
    output logic               o_full,
    output logic [BLOCK_W-1:0] o_block
);

    logic [BLOCK_W-1:0] r_buf;
    logic [4:0]         r_cnt;

    assign o_full  = (r_cnt == 5'(WORDS_PER_BLOCK));
    assign o_block = r_buf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_shift && !o_full) begin
            r_buf <= {r_buf[BLOCK_W-WORD_W-1:0], i_word};
            r_cnt <= r_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/wpa2_msg_block_fetcher.sv
// ---------------------------------------------------------------------------
// wpa2_msg_block_fetcher
// Avalon-MM read master that fetches num_blocks consecutive 16-word blocks
// from the WPA2 message memory and streams them as 512-bit SHA-1 blocks.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start, base_addr,
//   num_blocks          : command (sampled only while idle)
//   busy / done / err   : status; done and err are one-cycle pulses
//   mem_*               : Avalon-MM read master towards the memory
//   blk_data/valid/last : block stream out, blk_ready from the hash core
//   dbg_state           : current FSM state
// Reads for the next block begin only once the assembly buffer has been
// emptied into the output register, so read data can never be overrun.
// ---------------------------------------------------------------------------
module wpa2_msg_block_fetcher
    import wpa2_fetch_pkg::*;
#(
    parameter int MEM_DEPTH    = 6370,
    parameter int ADDR_W       = 13,
    parameter int NBLK_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [NBLK_W-1:0]  num_blocks,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_chipselect,
    output logic               mem_write,
    output logic [3:0]         mem_byteenable,
    output logic               mem_clken,
    input  logic [WORD_W-1:0]  mem_readdata,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_valid,
    output logic               blk_last,
    input  logic               blk_ready,
    output state_t             dbg_state
);

    localparam logic [31:0] DEPTH_U = MEM_DEPTH;

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_issue_cnt;
    logic                r_issue_done;
    logic [NBLK_W-1:0]   r_nblk;
    logic [NBLK_W-1:0]   r_blk_cnt;
    logic [READ_LATENCY-1:0] r_rd_pipe;
    logic [BLOCK_W-1:0]  r_blk_data;
    logic                r_blk_valid;
    logic                r_blk_last;
    logic                r_done;
    logic                r_err;

    logic                w_issue;
    logic                w_accept;
    logic                w_err_set;
    logic                w_done_set;
    logic                w_move;
    logic                w_capture;
    logic                w_full;
    logic [BLOCK_W-1:0]  w_block;
    logic                w_base_bad;
    logic                w_out_free;
    logic                w_fire;
    logic                w_is_last;
    logic [NBLK_W-1:0]   w_blk_cnt_inc;
    logic [ADDR_W-1:0]   w_next_addr;

    assign w_base_bad    = (32'(base_addr) >= DEPTH_U);
    assign w_fire        = r_blk_valid && blk_ready;
    // Output register can take a new block if empty or emptying this cycle.
    assign w_out_free    = !r_blk_valid || blk_ready;
    assign w_blk_cnt_inc = r_blk_cnt + NBLK_W'(1);
    assign w_is_last     = (w_blk_cnt_inc == r_nblk);
    assign w_next_addr   = ADDR_W'(wrap_next_addr(32'(r_addr), DEPTH_U));
    assign w_capture     = r_rd_pipe[READ_LATENCY-1];

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM next-state / control ----------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_err_set    = 1'b0;
        w_done_set   = 1'b0;
        w_move       = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_base_bad) begin
                        w_err_set = 1'b1;
                    end else if (num_blocks == '0) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                w_issue = !r_issue_done;
                if (w_full) begin
                    if (w_out_free) begin
                        w_move = 1'b1;
                        // After the final block, wait in STALL for the drain.
                        w_next_state = w_is_last ? STALL : FETCH;
                    end else begin
                        w_next_state = STALL;
                    end
                end
            end
            STALL: begin
                if (w_full) begin
                    if (w_out_free) begin
                        w_move = 1'b1;
                        if (!w_is_last) begin
                            w_next_state = FETCH;
                        end
                    end
                end else if (w_fire && r_blk_last) begin
                    w_done_set   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- address generator, pipe, output register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_issue_cnt  <= '0;
            r_issue_done <= 1'b0;
            r_nblk       <= '0;
            r_blk_cnt    <= '0;
            r_rd_pipe    <= '0;
            r_blk_data   <= '0;
            r_blk_valid  <= 1'b0;
            r_blk_last   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= w_done_set;
            r_err  <= w_err_set;

            // Shift-valid pipe: marks which cycles carry returning read data.
            r_rd_pipe[0] <= w_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end

            if (w_accept) begin
                r_addr       <= base_addr;
                r_nblk       <= num_blocks;
                r_blk_cnt    <= '0;
                r_issue_cnt  <= '0;
                r_issue_done <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_addr      <= w_next_addr;
                    r_issue_cnt <= r_issue_cnt + 4'd1;
                    if (r_issue_cnt == 4'(WORDS_PER_BLOCK - 1)) begin
                        r_issue_done <= 1'b1;
                    end
                end
                if (w_move) begin
                    r_blk_cnt <= w_blk_cnt_inc;
                    if (!w_is_last) begin
                        r_issue_done <= 1'b0;
                    end
                end
            end

            if (w_move) begin
                r_blk_data  <= w_block;
                r_blk_valid <= 1'b1;
                r_blk_last  <= w_is_last;
            end else if (w_fire) begin
                r_blk_valid <= 1'b0;
                r_blk_last  <= 1'b0;
            end
        end
    end

    wpa2_word_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_shift (w_capture),
        .i_word  (mem_readdata),
        .i_clear (w_move),
        .o_full  (w_full),
        .o_block (w_block)
    );

    assign busy           = (r_state != IDLE);
    assign done           = r_done;
    assign err            = r_err;
    assign mem_address    = r_addr;
    assign mem_chipselect = w_issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign blk_data       = r_blk_data;
    assign blk_valid      = r_blk_valid;
    assign blk_last       = r_blk_last;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_wpa2_msg_block_fetcher.sv
// ---------------------------------------------------------------------------
// tb_wpa2_msg_block_fetcher
// Directed bench for wpa2_msg_block_fetcher. The memory model returns each
// word's own address one cycle after a chipselect. A negedge monitor records
// issued addresses, accepted blocks and status pulses; the main sequence
// compares them with hand-computed values.
// ---------------------------------------------------------------------------
module tb_wpa2_msg_block_fetcher;
    import wpa2_fetch_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [12:0]  base_addr;
    logic [7:0]   num_blocks;
    logic         busy;
    logic         done;
    logic         err;
    logic [12:0]  mem_address;
    logic         mem_chipselect;
    logic         mem_write;
    logic [3:0]   mem_byteenable;
    logic         mem_clken;
    logic [31:0]  mem_readdata = 32'd0;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;
    state_t       dbg_state;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    wpa2_msg_block_fetcher dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_blocks     (num_blocks),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .blk_data       (blk_data),
        .blk_valid      (blk_valid),
        .blk_last       (blk_last),
        .blk_ready      (blk_ready),
        .dbg_state      (dbg_state)
    );

    // ---------------- memory model: word value = its address ----------------
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= {19'd0, mem_address};
    end

    // ---------------- monitor ----------------
    int           cyc = 0;
    logic [12:0]  addr_q[$];
    logic [511:0] blk_q[$];
    logic         last_q[$];
    int           vrise_q[$];
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           err_cnt = 0;
    int           busy_rise_cnt = 0;
    int           busy_rise_cyc = 0;
    int           hs_last_edge = 0;
    logic         prev_busy = 1'b0;
    logic         prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_chipselect) addr_q.push_back(mem_address);
        if (blk_valid && blk_ready) begin
            blk_q.push_back(blk_data);
            last_q.push_back(blk_last);
            if (blk_last) hs_last_edge = cyc + 1;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
        if (busy && !prev_busy) begin
            busy_rise_cnt++;
            busy_rise_cyc = cyc;
        end
        if (blk_valid && !prev_valid) vrise_q.push_back(cyc);
        prev_busy  = busy;
        prev_valid = blk_valid;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [511:0] b, input int i);
        return b[511-32*i -: 32];
    endfunction

    // Called at posedge+1; the command is sampled at the next posedge.
    task automatic do_start(input logic [12:0] b, input logic [7:0] n);
        start      = 1'b1;
        base_addr  = b;
        num_blocks = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_timeout"}, (done_cnt != d0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a0, b0, v0, d0, e0, r0, n;
        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_blocks = '0;
        blk_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cs", {31'd0, mem_chipselect}, 32'd0);
        check("rst_addr", {19'd0, mem_address}, 32'd0);
        check("rst_valid", {31'd0, blk_valid}, 32'd0);
        check("rst_last", {31'd0, blk_last}, 32'd0);
        check("rst_data", {31'd0, |blk_data}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("tie_write", {31'd0, mem_write}, 32'd0);
        check("tie_be", {28'd0, mem_byteenable}, 32'hF);
        check("tie_clken", {31'd0, mem_clken}, 32'd1);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // T1: base 0, one block
        a0 = addr_q.size(); b0 = blk_q.size(); v0 = vrise_q.size(); d0 = done_cnt;
        do_start(13'd0, 8'd1);
        wait_done(d0, 100, "t1");
        check("t1_nreads", addr_q.size() - a0, 16);
        for (int i = 0; i < 16; i++) check("t1_addr", {19'd0, addr_q[a0+i]}, i);
        check("t1_nblk", blk_q.size() - b0, 1);
        for (int i = 0; i < 16; i++) check("t1_word", word_of(blk_q[b0], i), i);
        check("t1_last", {31'd0, last_q[b0]}, 32'd1);
        check("t1_latency", vrise_q[v0] - busy_rise_cyc, 18);
        check("t1_done_after_hs", done_cyc - hs_last_edge, 0);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // T2: wrap across the end of memory, two blocks
        repeat (2) @(posedge clk);
        #1;
        a0 = addr_q.size(); b0 = blk_q.size(); v0 = vrise_q.size(); d0 = done_cnt;
        do_start(13'd6360, 8'd2);
        wait_done(d0, 120, "t2");
        check("t2_nreads", addr_q.size() - a0, 32);
        check("t2_addr0", {19'd0, addr_q[a0]}, 6360);
        check("t2_addr9", {19'd0, addr_q[a0+9]}, 6369);
        check("t2_addr10", {19'd0, addr_q[a0+10]}, 0);
        check("t2_addr31", {19'd0, addr_q[a0+31]}, 21);
        check("t2_nblk", blk_q.size() - b0, 2);
        check("t2_b1w0", word_of(blk_q[b0], 0), 6360);
        check("t2_b1w9", word_of(blk_q[b0], 9), 6369);
        check("t2_b1w10", word_of(blk_q[b0], 10), 0);
        check("t2_b1w15", word_of(blk_q[b0], 15), 5);
        check("t2_b2w0", word_of(blk_q[b0+1], 0), 6);
        check("t2_b2w15", word_of(blk_q[b0+1], 15), 21);
        check("t2_last1", {31'd0, last_q[b0]}, 32'd0);
        check("t2_last2", {31'd0, last_q[b0+1]}, 32'd1);
        check("t2_spacing", vrise_q[v0+1] - vrise_q[v0], 18);

        // T3: back-pressure, three blocks from 100
        repeat (2) @(posedge clk);
        #1;
        a0 = addr_q.size(); b0 = blk_q.size(); d0 = done_cnt;
        blk_ready = 1'b0;
        do_start(13'd100, 8'd3);
        n = 0;
        while (!blk_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("t3_valid_seen", {31'd0, blk_valid}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("t3_stall_state", {30'd0, dbg_state}, {30'd0, STALL});
        check("t3_stall_cs", {31'd0, mem_chipselect}, 32'd0);
        check("t3_reads_held", addr_q.size() - a0, 32);
        check("t3_hold_valid", {31'd0, blk_valid}, 32'd1);
        check("t3_hold_last", {31'd0, blk_last}, 32'd0);
        check("t3_hold_w0", word_of(blk_data, 0), 100);
        check("t3_hold_w15", word_of(blk_data, 15), 115);
        blk_ready = 1'b1;
        wait_done(d0, 120, "t3");
        check("t3_nblk", blk_q.size() - b0, 3);
        check("t3_b1w0", word_of(blk_q[b0], 0), 100);
        check("t3_b2w0", word_of(blk_q[b0+1], 0), 116);
        check("t3_b2w15", word_of(blk_q[b0+1], 15), 131);
        check("t3_b3w0", word_of(blk_q[b0+2], 0), 132);
        check("t3_b3w15", word_of(blk_q[b0+2], 15), 147);
        check("t3_last", {29'd0, last_q[b0], last_q[b0+1], last_q[b0+2]}, 32'b001);
        check("t3_nreads", addr_q.size() - a0, 48);

        // T4: rejected base address, then zero-block command
        repeat (2) @(posedge clk);
        #1;
        a0 = addr_q.size(); d0 = done_cnt; e0 = err_cnt; r0 = busy_rise_cnt;
        do_start(13'd6370, 8'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t4_err_pulse", err_cnt - e0, 1);
        check("t4_err_reads", addr_q.size() - a0, 0);
        check("t4_err_busy", busy_rise_cnt - r0, 0);
        check("t4_err_nodone", done_cnt - d0, 0);
        do_start(13'd5, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t4_zero_done", done_cnt - d0, 1);
        check("t4_zero_reads", addr_q.size() - a0, 0);
        check("t4_zero_busy", busy_rise_cnt - r0, 0);
        check("t4_zero_noerr", err_cnt - e0, 1);

        // T5: reset in the middle of block 1
        do_start(13'd200, 8'd2);
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_cs", {31'd0, mem_chipselect}, 32'd0);
        check("t5_rst_addr", {19'd0, mem_address}, 32'd0);
        check("t5_rst_valid", {31'd0, blk_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a0 = addr_q.size(); b0 = blk_q.size(); d0 = done_cnt;
        do_start(13'd300, 8'd1);
        wait_done(d0, 100, "t5");
        check("t5_nreads", addr_q.size() - a0, 16);
        check("t5_addr0", {19'd0, addr_q[a0]}, 300);
        check("t5_nblk", blk_q.size() - b0, 1);
        check("t5_w0", word_of(blk_q[b0], 0), 300);
        check("t5_w15", word_of(blk_q[b0], 15), 315);

        // T6: start while busy is ignored
        repeat (2) @(posedge clk);
        #1;
        a0 = addr_q.size(); b0 = blk_q.size(); d0 = done_cnt;
        do_start(13'd400, 8'd1);
        repeat (4) @(posedge clk);
        #1;
        do_start(13'd1000, 8'd2);
        wait_done(d0, 100, "t6");
        repeat (40) @(posedge clk);
        #1;
        check("t6_nreads", addr_q.size() - a0, 16);
        check("t6_nblk", blk_q.size() - b0, 1);
        check("t6_w0", word_of(blk_q[b0], 0), 400);
        check("t6_w15", word_of(blk_q[b0], 15), 415);
        check("t6_done_count", done_cnt - d0, 1);
        check("t6_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wpa2_msg_block_fetcher.md
Name: wpa2_msg_block_fetcher

Overview:
- Avalon-MM read master sitting directly downstream of the WPA2 on-chip message memory: 32-bit words, 13-bit word address, 6370 words, single port, 1-cycle read latency.
- On a start command it reads N consecutive 16-word blocks from the memory.
- It packs each block into a 512-bit SHA-1 message block and hands it to the hash core over a valid/ready stream.
- It is read-only; software/Nios fills the memory through the memory's other slave port.

Parameters:
- MEM_DEPTH, 6370, number of valid words in the memory; addresses wrap modulo this value.
- ADDR_W, 13, memory word-address width.
- NBLK_W, 8, width of the block-count command field.
- READ_LATENCY, 1, cycles from address sampled by memory to readdata valid.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe, sampled only when busy=0.
- base_addr  in  ADDR_W  first word address of the transfer.
- num_blocks  in  NBLK_W  number of 512-bit blocks to fetch.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse when start is rejected for a bad base_addr.
- mem_address  out  ADDR_W  memory word address.
- mem_chipselect  out  1  memory select; high only on read-issue cycles.
- mem_write  out  1  tied 0.
- mem_byteenable  out  4  tied 4'hF.
- mem_clken  out  1  tied 1.
- mem_readdata  in  32  memory read data.
- blk_data  out  512  packed block; first-read word in [511:480], 16th word in [31:0].
- blk_valid  out  1  blk_data valid.
- blk_last  out  1  final block of the transfer; qualified by blk_valid.
- blk_ready  in  1  hash core accepts the block.

Behaviour:
- Reset (async assert, sync release): busy, done, err, mem_chipselect, blk_valid and blk_last are 0; mem_address, blk_data and all counters are 0; state is IDLE. Reads still in flight are discarded.
- States: IDLE, FETCH, STALL.
- IDLE: when start=1, one of three things happens.
  - base_addr >= MEM_DEPTH: err pulses for one cycle; stay in IDLE.
  - num_blocks=0: done pulses the next cycle; no reads are issued; busy stays 0.
  - Otherwise: latch the command, busy=1, go to FETCH.
- Start while busy=1 is ignored.
- FETCH: issue one read per cycle for 16 cycles (mem_chipselect=1, mem_address = current address). The address increments by 1 and wraps MEM_DEPTH-1 -> 0.
- Data capture: readdata is captured READ_LATENCY cycles after each issue, via a shift-valid pipe, into the assembly buffer.
- Block complete (16th word captured):
  - If the output register is empty, or blk_valid & blk_ready in the same cycle, move the buffer to the output. blk_valid=1, and blk_last=1 if this is block num_blocks.
  - Otherwise go to STALL and issue no reads.
- STALL: leave when the output frees, transfer the buffer, then resume FETCH (more blocks remain) or wait for the drain.
- Reads for block k+1 start only after block k has left the assembly buffer. There is no overlap, so no read data is ever dropped.
- Output hold: blk_data, blk_valid and blk_last are held stable while blk_valid=1 and blk_ready=0.
- Timing with blk_ready held 1: the first blk_valid rises 18 cycles after the start-accept edge, and blocks are spaced 18 cycles apart.
- Completion: on the cycle blk_valid & blk_ready & blk_last, done=1 for one cycle, busy goes to 0, and the state returns to IDLE. A start in the following cycle is accepted.
- Read-issue counter is 4 bits, captured-word counter 5 bits, block counter NBLK_W bits; there is no overflow because num_blocks is at most 2^NBLK_W-1.

Decomposition:
- Package wpa2_fetch_pkg:
  - WORDS_PER_BLOCK=16 and BLOCK_W=512;
  - the state enum {IDLE, FETCH, STALL};
  - the next-address wrap function.
- Sub-module wpa2_word_packer:
  - 16x32 shift-in assembly buffer with a word counter and a full flag;
  - clear on consume.
- The top level holds the FSM, address generator, latency pipe and output register.

Test Plan:
- Memory words = address; start base=0, num_blocks=1, blk_ready=1 -> 16 reads at addresses 0..15; blk_data word0=0 through word15=15; blk_last=1; done one cycle after the handshake; first blk_valid 18 cycles after start.
- base=6360, num_blocks=2 -> addresses 6360..6369 then 0..21; block1 ends with word 5; block2 = words 6..21; blk_last only on block2.
- num_blocks=3, blk_ready low 40 cycles after block1 -> block2 assembled; STALL with no chipselect; block1 data held stable; after ready rises, blocks 2 and 3 are delivered in order with correct data.
- start with base=6370 -> err pulse, no reads, busy=0; start with num_blocks=0 -> done pulse, no reads.
- reset_n asserted mid-FETCH of block1 -> all outputs 0 immediately; a new start after release fetches cleanly from the new base.
- start asserted while busy -> ignored; the original transfer completes unchanged.
